scan_loader: RTL and testbench
==============================

# scan_loader

Configuration-chain programmer for the FPGA fabric. It accepts parallel configuration words from the bitstream source over a valid/ready handshake and serializes them MSB-first onto the scan chain formed by the daisy-chained `sram` config cells. It drives `scan_in`/`scan_en` for exactly `CHAIN_LEN` shift cycles per load, then reports completion. It is the writer side of the chain's shift-register interface and optionally collects the bits shifted out of the chain tail for readback.

## Interface
- `CHAIN_LEN`, 16: total config bits in the chain. Must be ≥ 1.
- `DATA_WIDTH`, 8: width of the parallel config word. Must be ≥ 1.

- `scan_clk`  in  1  chain shift clock; all state on posedge.
- `scan_rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  1-cycle request to begin a load; ignored while `busy`.
- `cfg_data`  in  DATA_WIDTH  config word, MSB shifted first.
- `cfg_valid`  in  1  `cfg_data` valid.
- `cfg_ready`  out  1  loader can accept a word this cycle.
- `chain_scan_in`  out  1  to the chain head `scan_in`.
- `chain_scan_en`  out  1  to every cell's `scan_en`.
- `chain_scan_out`  in  1  from the chain tail `scan_out`; used only with readback.
- `busy`  out  1  load in progress.
- `done`  out  1  last load completed; held until the next accepted `start`.
- `rb_data`  out  DATA_WIDTH  readback word (readback builds only).
- `rb_valid`  out  1  1-cycle strobe for `rb_data` (readback builds only).

## Operation
- Word transfer: a word is accepted on any edge with `cfg_valid && cfg_ready`.
- FSM states:
  - IDLE: on `start`, go to LOAD and set `busy=1`, `done=0`.
  - LOAD: `cfg_ready=1`. On accept, go to SHIFT.
  - SHIFT: present one bit per cycle. After the last bit of the word:
    - if chain bits remain and no word is accepted, go to LOAD;
    - if all `CHAIN_LEN` bits are sent, go to DONE.
  - DONE: for one cycle, set `busy=0` and `done=1`, then go to IDLE.
- Back-to-back words: `cfg_ready` is also high in SHIFT during the cycle that presents a word's last bit, but only when chain bits remain. A word accepted then is presented the next cycle with no bubble.
- Stall: if no word is available in LOAD, `chain_scan_en=0`. The chain holds and no bit is lost.
- Word count: ceil(CHAIN_LEN/DATA_WIDTH) words per load. In the final word, only the top CHAIN_LEN mod DATA_WIDTH bits are shifted when that value is nonzero. The rest are discarded.
- Bit placement: the first bit shifted ends at the chain's most-significant position after `CHAIN_LEN` shifts.
- Counters:
  - bit counter, $clog2(CHAIN_LEN+1) bits, counts to `CHAIN_LEN` exactly, no wrap;
  - in-word counter, $clog2(DATA_WIDTH) bits (1-bit minimum).
- `start` while `busy` is ignored. `start` while in DONE is ignored.
- Reset (any time, including mid-load):
  - state IDLE;
  - `busy`, `done`, `cfg_ready`, `chain_scan_en`, `chain_scan_in`, `rb_valid` = 0;
  - `rb_data` = 0.
  
  Chain contents are left partially shifted. A new `start` is required.

## Timing
- All outputs are registered.
- `start` at edge S: `busy=1` and `cfg_ready=1` after S.
- Word accepted at edge E:
  - after E: `chain_scan_en=1`, `chain_scan_in` = word MSB;
  - the chain shifts that bit at E+1;
  - bit k of the word (counting from the MSB) shifts at E+1+k.
- Continuous stream: exactly `CHAIN_LEN` shifting edges, contiguous.
- After the final shift edge F: `chain_scan_en=0`, `busy=0`, `done=1`.

## Configuration
- Macro `SCAN_READBACK_EN`.
- Defined:
  - `chain_scan_out` is sampled on every shifting edge, i.e. the value before the shift;
  - sampled bits are packed MSB-first into `DATA_WIDTH`-bit words;
  - `rb_valid` pulses for 1 cycle when a word fills;
  - a final partial word is left-aligned, zero-padded, and strobed on the DONE transition.
- Undefined: no readback logic. `rb_data` is tied to 0, `rb_valid` to 0, and `chain_scan_out` is unused.

## Structure
- Shared package `scan_pkg`: FSM state enum (IDLE, LOAD, SHIFT, DONE) and a width helper constant for `$clog2` minimum-1.
- Sub-module `scan_piso`: a DATA_WIDTH parallel-in serial-out shifter with load/shift enables and a last-bit flag. It is instantiated once in the data path.
- The readback packer stays inline under the macro.

## Test plan
- CHAIN_LEN=16, DATA_WIDTH=8, `cfg_valid` held high, words 0xA5 then 0x3C:
  - `start` at edge 0, first word accepted at edge 1, second at edge 9;
  - 16 contiguous shifts on edges 2–17;
  - chain model = 0xA53C;
  - `done=1` and `busy=0` after edge 17.
- CHAIN_LEN=12, DATA_WIDTH=8, words 0xF0, 0xAB: exactly 12 shifts, chain = 0xF0A, low nibble 0xB not shifted.
- Stall: `cfg_valid` dropped for 5 cycles between words. `chain_scan_en=0` for those cycles and the final chain value is unchanged versus the no-stall case.
- Reset mid-load: assert `scan_rst_n=0` after 5 shifts.
  - All outputs are 0 immediately (asynchronous).
  - After release, `start` plus a full load of 0xA5, 0x3C yields chain = 0xA53C.
- `start` pulsed while `busy`: no effect on the shift count or `done` timing.
- `SCAN_READBACK_EN`: preload the chain model with 0x1234, then program 0xA53C.
  - `rb_data` = 0x12 then 0x34, each with a 1-cycle `rb_valid`.
  - Chain = 0xA53C.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types for the scan-chain loader.
// FSM state encoding plus a clog2 helper that never returns 0.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_piso.sv
// Parallel-in serial-out shifter, MSB first.
// Tracks the in-word bit position and flags the word's last bit.
module scan_piso
  import scan_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int WW = clog2_min1(DATA_WIDTH)
) (
  input  logic                  scan_clk,
  input  logic                  scan_rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  sout,
  output logic                  last,
  output logic [WW-1:0]         pos
);

  logic [DATA_WIDTH-1:0] sreg;

  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      sreg <= '0;
      pos  <= '0;
    end else if (load) begin
      sreg <= din;
      pos  <= '0;
    end else if (shift) begin
      sreg <= sreg << 1;
      pos  <= last ? '0 : pos + WW'(1);
    end
  end

  assign sout = sreg[DATA_WIDTH-1];
  assign last = (pos == WW'(DATA_WIDTH - 1));

endmodule

// File: rtl/scan_loader.sv
// Scan-chain programmer: serializes config words onto the chain.
// Optional tail readback packer under `SCAN_READBACK_EN.
module scan_loader
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  scan_clk,
  input  logic                  scan_rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  chain_scan_in,
  output logic                  chain_scan_en,
  input  logic                  chain_scan_out,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rb_data,
  output logic                  rb_valid
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int WW = clog2_min1(DATA_WIDTH);
  localparam logic [BW-1:0] BLAST = BW'(CHAIN_LEN - 1);
  localparam logic [WW-1:0] WLAST = WW'(DATA_WIDTH - 1);

  state_t        state, state_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [WW-1:0] pos, pos_n;
  logic          accept, load, shift;
  logic          last, chain_last, word_end;
  logic          busy_n, done_n, ready_n;

  assign accept     = cfg_valid && cfg_ready;
  assign chain_last = (bcnt == BLAST);
  assign word_end   = last || chain_last;

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_n = LOAD;
        bcnt_n  = '0;
      end
      LOAD: if (accept) begin
        state_n = SHIFT;
        load    = 1'b1;
      end
      SHIFT: begin
        shift  = 1'b1;
        bcnt_n = bcnt + BW'(1);
        if (word_end) begin
          if (chain_last) state_n = DONE;
          else if (accept) load = 1'b1;
          else state_n = LOAD;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Ready is registered, so look one cycle ahead at the next position.
  always_comb begin
    pos_n = pos;
    if (load) pos_n = '0;
    else if (shift) pos_n = last ? '0 : pos + WW'(1);
    ready_n = (state_n == LOAD) ||
              (state_n == SHIFT && pos_n == WLAST &&
               bcnt_n != BLAST);
    busy_n = (state_n == LOAD) || (state_n == SHIFT);
    done_n = done;
    if (state == IDLE && start) done_n = 1'b0;
    if (state_n == DONE) done_n = 1'b1;
  end

  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      state         <= IDLE;
      bcnt          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_ready     <= 1'b0;
      chain_scan_en <= 1'b0;
    end else begin
      state         <= state_n;
      bcnt          <= bcnt_n;
      busy          <= busy_n;
      done          <= done_n;
      cfg_ready     <= ready_n;
      chain_scan_en <= (state_n == SHIFT);
    end
  end

  scan_piso #(.DATA_WIDTH(DATA_WIDTH)) u_piso (
    .scan_clk   (scan_clk),
    .scan_rst_n (scan_rst_n),
    .load       (load),
    .shift      (shift),
    .din        (cfg_data),
    .sout       (chain_scan_in),
    .last       (last),
    .pos        (pos)
  );

`ifdef SCAN_READBACK_EN
  logic [DATA_WIDTH-1:0] rb_sh, rb_cat;

  assign rb_cat = (rb_sh << 1) | DATA_WIDTH'(chain_scan_out);

  // A short final word is left-aligned by the unused bit count.
  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      rb_sh    <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (shift) begin
        rb_sh <= rb_cat;
        if (word_end) begin
          rb_valid <= 1'b1;
          rb_data  <= rb_cat << (WLAST - pos);
        end
      end
    end
  end
`else
  logic unused_scan_out;

  assign unused_scan_out = chain_scan_out;
  assign rb_data         = '0;
  assign rb_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_scan_loader.sv
// Bench for scan_loader: 16/8 and 12/8 instances driving chain models.
// Readback checks run only when SCAN_READBACK_EN is defined.
module tb_scan_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start [2];
  logic       cfg_valid [2];
  logic       cfg_ready [2];
  logic       sin [2];
  logic       sen [2];
  logic       sout [2];
  logic       busy [2];
  logic       done [2];
  logic       rb_valid [2];
  logic [7:0] cfg_data [2];
  logic [7:0] rb_data [2];

  logic [15:0] chain0 = '0;
  logic [11:0] chain1 = '0;
  logic        pre_req;
  logic [15:0] pre_val;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [63:0] exp_bits [2];
  int exp_n [2];
  int exp_i [2];
  int nsh [2];
  int first_sh [2];
  int last_sh [2];
  logic [7:0] rb_log [4];
  int rb_n;

  always #5 clk = ~clk;

  scan_loader #(.CHAIN_LEN(16), .DATA_WIDTH(8)) u_dut16 (
    .scan_clk(clk), .scan_rst_n(rst_n), .start(start[0]),
    .cfg_data(cfg_data[0]), .cfg_valid(cfg_valid[0]),
    .cfg_ready(cfg_ready[0]), .chain_scan_in(sin[0]),
    .chain_scan_en(sen[0]), .chain_scan_out(sout[0]),
    .busy(busy[0]), .done(done[0]),
    .rb_data(rb_data[0]), .rb_valid(rb_valid[0])
  );

  scan_loader #(.CHAIN_LEN(12), .DATA_WIDTH(8)) u_dut12 (
    .scan_clk(clk), .scan_rst_n(rst_n), .start(start[1]),
    .cfg_data(cfg_data[1]), .cfg_valid(cfg_valid[1]),
    .cfg_ready(cfg_ready[1]), .chain_scan_in(sin[1]),
    .chain_scan_en(sen[1]), .chain_scan_out(sout[1]),
    .busy(busy[1]), .done(done[1]),
    .rb_data(rb_data[1]), .rb_valid(rb_valid[1])
  );

  // The chains themselves: shift registers fed at the head.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_req) chain0 <= pre_val;
    else if (sen[0]) chain0 <= {chain0[14:0], sin[0]};
    if (sen[1]) chain1 <= {chain1[10:0], sin[1]};
  end

  assign sout[0] = chain0[15];
  assign sout[1] = chain1[11];

  function automatic int clen(input int i);
    return (i == 0) ? 16 : 12;
  endfunction

  function automatic logic [15:0] chain_of(input int i);
    return (i == 0) ? chain0 : {4'h0, chain1};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Every shifting cycle must present the next bit of the word stream.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (sen[i]) begin
          chk("en_while_busy", busy[i], 1);
          if (exp_i[i] >= exp_n[i])
            chk("extra_shift", exp_i[i], exp_n[i]);
          else
            chk("scan_in", sin[i], exp_bits[i][63 - exp_i[i]]);
          if (nsh[i] == 0) first_sh[i] = cyc + 1;
          last_sh[i] = cyc + 1;
          nsh[i]++;
          exp_i[i]++;
        end
        if (!busy[i]) chk("ready_idle", cfg_ready[i], 0);
`ifndef SCAN_READBACK_EN
        chk("rb_off", {rb_valid[i], rb_data[i]}, 0);
`endif
      end
`ifdef SCAN_READBACK_EN
      if (rb_valid[0] && rb_n < 4) begin
        rb_log[rb_n] = rb_data[0];
        rb_n++;
      end
`endif
    end
  end

  task automatic run_load(input int i,
                          input logic [7:0] w0, w1,
                          input int stall,
                          input bit pulse_busy,
                          input bit pulse_done);
    int s, e0, e1, k, t, fd;
    bit acc, pb;
    logic [15:0] cat;
    cat = {w0, w1};
    exp_bits[i] = {w0, w1, 48'h0};
    exp_n[i] = clen(i);
    exp_i[i] = 0;
    nsh[i] = 0;
    e0 = -1;
    e1 = -1;
    @(posedge clk); #1;
    start[i] = 1'b1;
    cfg_valid[i] = 1'b1;
    cfg_data[i] = w0;
    @(posedge clk); #1;
    s = cyc;
    start[i] = 1'b0;
    k = 0;
    t = 0;
    while (k < 2 && t < 200) begin
      @(negedge clk);
      acc = cfg_valid[i] && cfg_ready[i];
      @(posedge clk); #1;
      t++;
      if (acc) begin
        if (k == 0) begin
          e0 = cyc - s;
          cfg_data[i] = w1;
          if (stall > 0) begin
            cfg_valid[i] = 1'b0;
            repeat (stall + 7) @(posedge clk);
            #1;
            cfg_valid[i] = 1'b1;
          end
        end else begin
          e1 = cyc - s;
          cfg_valid[i] = 1'b0;
        end
        k++;
      end
      start[i] = pulse_busy && (cyc - s == 5);
    end
    start[i] = 1'b0;
    chk("accepts", k, 2);
    chk("accept0_edge", e0, 1);
    chk("accept1_edge", e1, 9 + stall);
    t = 0;
    pb = 1'b1;
    do begin
      @(negedge clk); #1;
      t++;
      if (!done[i]) pb = busy[i];
    end while (!done[i] && t < 100);
    fd = cyc - s;
    chk("done_seen", done[i], 1);
    chk("done_edge", fd, clen(i) + 1 + stall);
    chk("busy_before_done", pb, 1);
    chk("busy_at_done", busy[i], 0);
    chk("en_at_done", sen[i], 0);
    chk("shift_count", nsh[i], clen(i));
    chk("first_shift", first_sh[i] - s, 2);
    chk("en_gap", last_sh[i] - first_sh[i] + 1 - nsh[i], stall);
    chk("chain_model", chain_of(i), cat >> (16 - clen(i)));
    if (pulse_done) begin
      start[i] = 1'b1;
      @(posedge clk); #1;
      start[i] = 1'b0;
      @(negedge clk); #1;
      chk("start_in_done_busy", busy[i], 0);
      chk("start_in_done_done", done[i], 1);
      chk("start_in_done_rdy", cfg_ready[i], 0);
    end
  endtask

  task automatic chk_zero(input string name, input int i);
    chk(name, {busy[i], done[i], cfg_ready[i], sen[i],
               sin[i], rb_valid[i], rb_data[i]}, 0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      cfg_valid[i] = 1'b0;
      cfg_data[i] = 8'h00;
      exp_bits[i] = '0;
      exp_n[i] = 0;
      exp_i[i] = 0;
      nsh[i] = 0;
    end
    pre_req = 1'b0;
    pre_val = '0;
    rb_n = 0;

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_outs16", 0);
    chk_zero("reset_outs12", 1);
    rst_n = 1'b1;

    run_load(0, 8'hA5, 8'h3C, 0, 1'b0, 1'b0);
    chk("chain_a53c", chain0, 16'hA53C);

    run_load(1, 8'hF0, 8'hAB, 0, 1'b0, 1'b0);
    chk("chain12_f0a", chain1, 12'hF0A);

    run_load(0, 8'h0F, 8'hF0, 0, 1'b1, 1'b1);
    chk("chain_0ff0", chain0, 16'h0FF0);

    run_load(0, 8'hA5, 8'h3C, 5, 1'b0, 1'b0);
    chk("chain_stall", chain0, 16'hA53C);

    // Reset after five shifts of a fresh load.
    @(posedge clk); #1;
    exp_bits[0] = {8'h5A, 56'h0};
    exp_n[0] = 16;
    exp_i[0] = 0;
    nsh[0] = 0;
    start[0] = 1'b1;
    cfg_valid[0] = 1'b1;
    cfg_data[0] = 8'h5A;
    @(posedge clk); #1;
    start[0] = 1'b0;
    t = 0;
    while (nsh[0] < 5 && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    chk("mid_load_reached", nsh[0], 5);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset16", 0);
    chk_zero("async_reset12", 1);
    cfg_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_load(0, 8'hA5, 8'h3C, 0, 1'b0, 1'b0);
    chk("chain_after_reset", chain0, 16'hA53C);

`ifdef SCAN_READBACK_EN
    pre_val = 16'h1234;
    @(posedge clk); #1;
    pre_req = 1'b1;
    @(posedge clk); #1;
    pre_req = 1'b0;
    rb_n = 0;
    run_load(0, 8'hA5, 8'h3C, 0, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("rb_count", rb_n, 2);
    chk("rb_word0", rb_log[0], 8'h12);
    chk("rb_word1", rb_log[1], 8'h34);
    chk("chain_rb", chain0, 16'hA53C);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
